mem_arbiter_2p: RTL and testbench

//  Round-robin arbiter sharing one main-memory port between two cache controllers (e.g. I- and D-side cache_2wsa).

---
 rtl/mem_arbiter_2p.sv | 113 +++++++++++
 tb/tb_mem_arbiter_2p.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: round-robin arbiter granting one of two cache ports a whole line burst on a shared memory port
module mem_arbiter_2p #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_rd,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ready,
  output logic              r0_done,
  output logic              r0_err,
  input  logic              r1_rd,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ready,
  output logic              r1_done,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_n;
  logic op, err, last;
  logic [ADDR_W-BW-1:0] base;
  logic [BW-1:0] beat;
  logic [WW-1:0] wdog;
  logic req0, req1, pick1, last_beat, timeout, active, fin;
  logic addr_unused;
  assign addr_unused = ^{r0_addr[BW-1:0], r1_addr[BW-1:0]};
  assign req0 = r0_rd | r0_wr;
  assign req1 = r1_rd | r1_wr;
  // on a tie, port 1 wins only if port 0 was served last
  assign pick1 = req1 & (~req0 | ~last);
  assign last_beat = beat == BW'(BURST_LEN - 1);
  assign timeout = (TIMEOUT != 0) && (wdog == WW'(TIMEOUT - 1));
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (req0 | req1) ? ACTIVE : IDLE;
      ACTIVE:  state_n = (mem_ready ? last_beat : timeout) ? DONE : ACTIVE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      grant <= '0;
      op    <= 1'b0;
      err   <= 1'b0;
      last  <= 1'b1;
      base  <= '0;
      beat  <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          grant <= pick1 ? 2'b10 : 2'b01;
          op    <= pick1 ? r1_wr : r0_wr;
          base  <= pick1 ? r1_addr[ADDR_W-1:BW] : r0_addr[ADDR_W-1:BW];
          beat  <= '0;
          wdog  <= '0;
          err   <= 1'b0;
        end
        ACTIVE: if (mem_ready) begin
          beat <= beat + 1'b1;
          wdog <= '0;
        end else begin
          wdog <= wdog + 1'b1;
          if (timeout) err <= 1'b1;
        end
        DONE: begin
          last  <= grant[1];
          grant <= '0;
        end
        default: ;
      endcase
    end
  end
  assign active = state == ACTIVE;
  assign fin    = state == DONE;
  always_comb begin
    mem_rd    = active & ~op;
    mem_wr    = active & op;
    mem_addr  = active ? {base, beat} : '0;
    mem_wdata = active ? (grant[1] ? r1_wdata : r0_wdata) : '0;
    r0_rdata  = (active & grant[0]) ? mem_rdata : '0;
    r1_rdata  = (active & grant[1]) ? mem_rdata : '0;
    r0_ready  = active & grant[0] & mem_ready;
    r1_ready  = active & grant[1] & mem_ready;
    r0_done   = fin & grant[0];
    r1_done   = fin & grant[1];
    r0_err    = fin & grant[0] & err;
    r1_err    = fin & grant[1] & err;
  end
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p: directed bench for mem_arbiter_2p with a per-cycle reference model and literal checks
module tb_mem_arbiter_2p;
  localparam int BL = 4;
  localparam int TO = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic r0_rd = 0, r0_wr = 0, r1_rd = 0, r1_wr = 0;
  logic [15:0] r0_addr = 0, r1_addr = 0;
  logic [7:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic r0_ready, r0_done, r0_err, r1_ready, r1_done, r1_err;
  logic [15:0] mem_addr;
  logic mem_rd, mem_wr, mem_ready = 1'b1;
  logic [1:0] grant, prev_grant = 2'b00;
  int tests = 0, fails = 0, cyc = 0, mode = 0;
  int rdy_cnt[2] = '{0, 0};
  int done_cnt[2] = '{0, 0};
  int err_cnt[2] = '{0, 0};
  int rd_cyc = 0;
  int log_q[$];
  int wq[$];
  int rq[$];
  int aq[$];
  int m_phase = 0, m_own = 0, m_wr = 0, m_line = 0, m_beat = 0, m_stall = 0, m_last = 1, m_err = 0;
  int q0, q1, act, fin;

  mem_arbiter_2p #(.ADDR_W(16), .DATA_W(8), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .r0_rd(r0_rd), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(r0_rdata), .r0_ready(r0_ready), .r0_done(r0_done), .r0_err(r0_err),
    .r1_rd(r1_rd), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(r1_rdata), .r1_ready(r1_ready), .r1_done(r1_done), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
  );

  always #5 clock = ~clock;

  // memory returns 11,22,33,44 by beat; requesters present beat-indexed write data
  always_comb mem_rdata = 8'h11 * (8'(mem_addr[1:0]) + 8'd1);
  always_comb r0_wdata = 8'h50 + 8'(mem_addr[1:0]);
  always_comb r1_wdata = 8'hAA + 8'h11 * 8'(mem_addr[1:0]);

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  always @(negedge clock) begin
    act = int'(m_phase == 1);
    fin = int'(m_phase == 2);
    check("grant", 32'(grant), m_phase != 0 ? (1 << m_own) : 0);
    check("mem_rd", 32'(mem_rd), 32'(act != 0 && m_wr == 0));
    check("mem_wr", 32'(mem_wr), 32'(act != 0 && m_wr != 0));
    check("mem_addr", 32'(mem_addr), act != 0 ? m_line + m_beat : 0);
    check("mem_wdata", 32'(mem_wdata), act != 0 ? 32'(m_own != 0 ? r1_wdata : r0_wdata) : 0);
    check("r0_ready", 32'(r0_ready), 32'(act != 0 && m_own == 0 && mem_ready));
    check("r1_ready", 32'(r1_ready), 32'(act != 0 && m_own == 1 && mem_ready));
    check("r0_rdata", 32'(r0_rdata), (act != 0 && m_own == 0) ? 32'(mem_rdata) : 0);
    check("r1_rdata", 32'(r1_rdata), (act != 0 && m_own == 1) ? 32'(mem_rdata) : 0);
    check("r0_done", 32'(r0_done), 32'(fin != 0 && m_own == 0));
    check("r1_done", 32'(r1_done), 32'(fin != 0 && m_own == 1));
    check("r0_err", 32'(r0_err), 32'(fin != 0 && m_own == 0 && m_err != 0));
    check("r1_err", 32'(r1_err), 32'(fin != 0 && m_own == 1 && m_err != 0));
    if (r0_ready) begin
      rdy_cnt[0]++;
      rq.push_back(int'(r0_rdata));
      aq.push_back(int'(mem_addr));
    end
    if (r1_ready) rdy_cnt[1]++;
    if (r0_done) done_cnt[0]++;
    if (r1_done) done_cnt[1]++;
    if (r0_err) err_cnt[0]++;
    if (r1_err) err_cnt[1]++;
    if (mem_rd) rd_cyc++;
    if (mem_wr && mem_ready) wq.push_back(int'({mem_addr, mem_wdata}));
    if (grant != 2'b00 && prev_grant == 2'b00) log_q.push_back(grant == 2'b10 ? 1 : 0);
    prev_grant = grant;
    if (reset) begin
      m_phase = 0;
      m_last = 1;
    end else if (m_phase == 0) begin
      q0 = int'(r0_rd | r0_wr);
      q1 = int'(r1_rd | r1_wr);
      if (q0 != 0 || q1 != 0) begin
        m_own = (q0 != 0 && q1 != 0) ? 1 - m_last : (q1 != 0 ? 1 : 0);
        m_wr = int'(m_own != 0 ? r1_wr : r0_wr);
        m_line = int'(m_own != 0 ? r1_addr : r0_addr) & ~(BL - 1);
        m_beat = 0;
        m_stall = 0;
        m_err = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ready) begin
        if (m_beat == BL - 1) m_phase = 2;
        m_beat = (m_beat + 1) % BL;
        m_stall = 0;
      end else begin
        m_stall++;
        if (m_stall == TO) begin
          m_phase = 2;
          m_err = 1;
        end
      end
    end else begin
      m_last = m_own;
      m_phase = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    mem_ready = mode == 0 ? 1'b1 : (mode == 1 ? (cyc % 3 == 0) : 1'b0);
  endtask

  task automatic wait_done(input int p, input int n);
    for (int i = 0; i < 300 && done_cnt[p] < n; i++) tick();
    check($sformatf("wait_done%0d", p), 32'(done_cnt[p] >= n), 1);
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 300 && log_q.size() < n; i++) tick();
    check("wait_grant", 32'(log_q.size() >= n), 1);
  endtask

  initial begin
    int base, d0, n;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_r0_done", 32'(r0_done), 0);
    reset = 0;
    // single read of line C088
    r0_rd = 1; r0_addr = 16'hC08B;
    tick();
    r0_rd = 0;
    wait_done(0, 1);
    tick();
    check("t1_beats", 32'(rdy_cnt[0]), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(aq[i]), 32'h0000C088 + 32'(i));
      check("t1_rdata", 32'(rq[i]), 32'h11 * 32'(i + 1));
    end
    check("t1_owner", 32'(log_q[0]), 0);
    // simultaneous requests straight out of reset
    reset = 1;
    r0_rd = 1; r0_addr = 16'h0010;
    r1_wr = 1; r1_addr = 16'h0090;
    tick(); tick();
    reset = 0;
    wait_log(3);
    r1_wr = 0;
    wait_log(4);
    r0_rd = 0;
    wait_done(0, 3);
    tick();
    check("t2_first", 32'(log_q[1]), 0);
    check("t2_second", 32'(log_q[2]), 1);
    check("t2_third", 32'(log_q[3]), 0);
    check("t2_nwr", 32'(wq.size()), 4);
    check("t2_w0", 32'(wq[0]), 32'h0090AA);
    check("t2_w1", 32'(wq[1]), 32'h0091BB);
    check("t2_w2", 32'(wq[2]), 32'h0092CC);
    check("t2_w3", 32'(wq[3]), 32'h0093DD);
    // stalled beats
    mode = 1;
    base = rdy_cnt[0];
    n = aq.size();
    r0_rd = 1; r0_addr = 16'h1234;
    tick();
    r0_rd = 0;
    wait_done(0, 4);
    mode = 0;
    tick();
    check("t3_beats", 32'(rdy_cnt[0] - base), 4);
    for (int i = 0; i < 4; i++) check("t3_addr", 32'(aq[n + i]), 32'h1234 + 32'(i));
    // watchdog abort
    mode = 2;
    base = rd_cyc;
    r1_rd = 1; r1_addr = 16'h2000;
    tick();
    r1_rd = 0;
    wait_done(1, 2);
    check("t4_err", 32'(err_cnt[1]), 1);
    check("t4_rd_cycles", 32'(rd_cyc - base), 8);
    check("t4_idle_grant", 32'(grant), 0);
    check("t4_idle_rd", 32'(mem_rd), 0);
    mode = 0;
    tick();
    // reset in the middle of a burst
    d0 = done_cnt[0];
    base = rdy_cnt[0];
    r0_rd = 1; r0_addr = 16'h3000;
    tick();
    r0_rd = 0;
    for (int i = 0; i < 50 && rdy_cnt[0] - base < 2; i++) tick();
    check("t5_two_beats", 32'(rdy_cnt[0] - base), 2);
    reset = 1;
    tick();
    check("t5_grant", 32'(grant), 0);
    check("t5_mem_rd", 32'(mem_rd), 0);
    check("t5_mem_addr", 32'(mem_addr), 0);
    check("t5_r0_ready", 32'(r0_ready), 0);
    check("t5_no_done", 32'(done_cnt[0]), 32'(d0));
    r0_rd = 1; r0_addr = 16'h4000;
    r1_rd = 1; r1_addr = 16'h5000;
    tick();
    reset = 0;
    n = log_q.size();
    wait_log(n + 1);
    check("t5_first", 32'(log_q[n]), 0);
    r0_rd = 0;
    wait_log(n + 2);
    check("t5_second", 32'(log_q[n + 1]), 1);
    r1_rd = 0;
    wait_done(1, 3);
    check("t5_r0_done", 32'(done_cnt[0]), 32'(d0 + 1));
    // request held past done: the other port goes next
    n = log_q.size();
    r0_rd = 1; r0_addr = 16'h6000;
    wait_log(n + 1);
    r1_rd = 1; r1_addr = 16'h7000;
    wait_log(n + 2);
    check("t6_first", 32'(log_q[n]), 0);
    check("t6_second", 32'(log_q[n + 1]), 1);
    r1_rd = 0;
    wait_log(n + 3);
    check("t6_third", 32'(log_q[n + 2]), 0);
    r0_rd = 0;
    wait_done(0, d0 + 3);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
